cmd_frame_ctrl: RTL
===================

CMD_FRAME_CTRL -- requirements
Module: cmd_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning RX byte and register-write data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning register-file address width.
REQ-003 SHALL have parameter FUN_WIDTH, default 4, meaning ALU function-code width.
REQ-004 SHALL have ports, one per line, name direction width meaning:
  CLK  in  1  single system clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  RX_P_DATA  in  DATA_WIDTH  received UART byte.
  RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid.
  ALU_OUT_valid  in  1  ALU result ready.
  Address  out  ADDR_WIDTH  register-file address.
  WrEn  out  1  register write strobe.
  RdEn  out  1  register read strobe.
  Wr_data  out  DATA_WIDTH  register write data.
  ALU_FUN  out  FUN_WIDTH  ALU operation select.
  ALU_EN  out  1  ALU start strobe.
  CLK_GATE_EN  out  1  ALU clock-gate enable.
  CMD_ERR  out  1  one-cycle pulse, illegal opcode or dropped byte.

Function
REQ-005 SHALL accept one byte per cycle where RX_D_VLD=1; bytes at other cycles ignored.
REQ-006 SHALL decode first frame byte: 0xAA reg write (addr, data); 0xBB reg read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU no operands (fun).
REQ-007 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN, ALU_WAIT.
REQ-008 IDLE: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OP_A, 0xDD->ALU_FUN; any other opcode stays IDLE, CMD_ERR pulses next cycle.
REQ-009 WR_ADDR: latch byte[ADDR_WIDTH-1:0] as address, ->WR_DATA.
REQ-010 WR_DATA: next cycle WrEn=1 one cycle, Address=latched, Wr_data=byte; ->IDLE.
REQ-011 RD_ADDR: next cycle RdEn=1 one cycle, Address=byte[ADDR_WIDTH-1:0]; ->IDLE.
REQ-012 OP_A: next cycle WrEn=1, Address=0, Wr_data=byte; ->OP_B. OP_B: same with Address=1; ->ALU_FUN.
REQ-013 ALU_FUN: next cycle ALU_EN=1 one cycle, ALU_FUN=byte[FUN_WIDTH-1:0] held until next ALU command; CLK_GATE_EN=1 same cycle; ->ALU_WAIT.
REQ-014 ALU_WAIT: CLK_GATE_EN held 1; on ALU_OUT_valid=1, CLK_GATE_EN=0 next cycle, ->IDLE.
REQ-015 RX_D_VLD in ALU_WAIT: byte dropped, CMD_ERR pulses next cycle, state unchanged; same cycle as ALU_OUT_valid: still dropped, exit to IDLE.
REQ-016 All outputs SHALL be registered; latency byte-accept to strobe = 1 cycle; WrEn, RdEn, ALU_EN mutually exclusive.
REQ-017 Back-to-back frames on consecutive RX_D_VLD cycles SHALL be handled with no lost byte outside ALU_WAIT.
REQ-018 Address and Wr_data SHALL hold last driven value when strobes low.

Reset
REQ-019 rst_n low SHALL force IDLE and all outputs 0 asynchronously, including mid-frame; partial frame discarded.
REQ-020 First byte after rst_n release SHALL be treated as an opcode.

Structure
REQ-021 Opcodes 0xAA/0xBB/0xCC/0xDD, state encoding, and operand addresses 0/1 SHALL live in the shared system package.
REQ-022 No sub-module; single FSM plus output registers.

Verification
REQ-023 Bytes AA,05,3C -> one cycle WrEn=1, Address=5, Wr_data=0x3C; no RdEn/ALU_EN.
REQ-024 Bytes BB,07 -> one cycle RdEn=1, Address=7.
REQ-025 Bytes CC,12,34,02 -> writes 0x12@0, 0x34@1, then ALU_EN=1 ALU_FUN=2, CLK_GATE_EN=1 until cycle after ALU_OUT_valid.
REQ-026 Byte 0x55 in IDLE -> CMD_ERR one cycle, next DD,01 -> ALU_EN=1 ALU_FUN=1.
REQ-027 rst_n low after AA,05 then release, then BB,03 -> no WrEn ever, RdEn=1 Address=3.

Source files
------------

// File: rtl/cmd_frame_ctrl_pkg.sv
// Shared constants for the command-frame controller: default widths,
// frame opcodes, FSM state encoding and the ALU operand register addresses.
package cmd_frame_ctrl_pkg;

  // Default parameter values shared by the interface and the controller
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_FUN_WIDTH  = 4;

  // First byte of every frame selects the command
  localparam int unsigned OPC_WIDTH = 8;
  localparam logic [OPC_WIDTH-1:0] OPC_REG_WR  = 8'hAA;  // AA addr data
  localparam logic [OPC_WIDTH-1:0] OPC_REG_RD  = 8'hBB;  // BB addr
  localparam logic [OPC_WIDTH-1:0] OPC_ALU_OPS = 8'hCC;  // CC A B fun
  localparam logic [OPC_WIDTH-1:0] OPC_ALU_NOP = 8'hDD;  // DD fun

  // FSM state encoding
  localparam int unsigned ST_WIDTH = 3;
  localparam logic [ST_WIDTH-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_WIDTH-1:0] ST_WR_ADDR  = 3'd1;
  localparam logic [ST_WIDTH-1:0] ST_WR_DATA  = 3'd2;
  localparam logic [ST_WIDTH-1:0] ST_RD_ADDR  = 3'd3;
  localparam logic [ST_WIDTH-1:0] ST_OP_A     = 3'd4;
  localparam logic [ST_WIDTH-1:0] ST_OP_B     = 3'd5;
  localparam logic [ST_WIDTH-1:0] ST_ALU_FUN  = 3'd6;
  localparam logic [ST_WIDTH-1:0] ST_ALU_WAIT = 3'd7;

  // Register-file locations of the ALU operands
  localparam int unsigned OPND_A_ADDR = 0;
  localparam int unsigned OPND_B_ADDR = 1;

endpackage

// File: rtl/cmd_frame_ctrl_if.sv
// Bundle between the command-frame controller and its surroundings.
//   RX_P_DATA/RX_D_VLD  : received UART byte and its one-cycle strobe
//   ALU_OUT_valid       : ALU result ready
//   Address/WrEn/RdEn/Wr_data : register-file access
//   ALU_FUN/ALU_EN/CLK_GATE_EN : ALU control
//   CMD_ERR             : illegal opcode / dropped byte pulse
// master = controller side, slave = environment (UART, register file, ALU).
interface cmd_frame_ctrl_if
  import cmd_frame_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned FUN_WIDTH  = DEF_FUN_WIDTH
) ();

  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  ALU_OUT_valid;
  logic [ADDR_WIDTH-1:0] Address;
  logic                  WrEn;
  logic                  RdEn;
  logic [DATA_WIDTH-1:0] Wr_data;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic                  ALU_EN;
  logic                  CLK_GATE_EN;
  logic                  CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT_valid,
    output Address, WrEn, RdEn, Wr_data, ALU_FUN, ALU_EN, CLK_GATE_EN, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, ALU_OUT_valid,
    input  Address, WrEn, RdEn, Wr_data, ALU_FUN, ALU_EN, CLK_GATE_EN, CMD_ERR
  );

endinterface

// File: rtl/cmd_frame_ctrl.sv
// Command-frame controller: parses UART byte frames into register-file
// writes/reads and ALU commands. One FSM plus registered outputs; every
// strobe appears exactly one cycle after the byte that completes it.
// Ports:
//   CLK   : system clock, rising edge
//   rst_n : asynchronous active-low reset (forces IDLE, all outputs 0)
//   bus   : cmd_frame_ctrl_if master modport (RX byte in, reg/ALU control out)
module cmd_frame_ctrl
  import cmd_frame_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned FUN_WIDTH  = DEF_FUN_WIDTH
) (
  input logic              CLK,
  input logic              rst_n,
  cmd_frame_ctrl_if.master bus
);

  logic [ST_WIDTH-1:0]   state_q,       state_d;
  logic [ADDR_WIDTH-1:0] addr_lat_q,    addr_lat_d;
  logic [ADDR_WIDTH-1:0] address_q,     address_d;
  logic [DATA_WIDTH-1:0] wr_data_q,     wr_data_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q,     alu_fun_d;
  logic                  wr_en_q,       wr_en_d;
  logic                  rd_en_q,       rd_en_d;
  logic                  alu_en_q,      alu_en_d;
  logic                  clk_gate_en_q, clk_gate_en_d;
  logic                  cmd_err_q,     cmd_err_d;

  logic                  rx_vld;
  logic [DATA_WIDTH-1:0] rx_byte;
  logic [ADDR_WIDTH-1:0] rx_addr;
  logic [FUN_WIDTH-1:0]  rx_fun;

  assign rx_vld  = bus.RX_D_VLD;
  assign rx_byte = bus.RX_P_DATA;
  assign rx_addr = bus.RX_P_DATA[ADDR_WIDTH-1:0];
  assign rx_fun  = bus.RX_P_DATA[FUN_WIDTH-1:0];

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    addr_lat_d    = addr_lat_q;
    address_d     = address_q;
    wr_data_d     = wr_data_q;
    alu_fun_d     = alu_fun_q;
    clk_gate_en_d = clk_gate_en_q;
    wr_en_d       = 1'b0;
    rd_en_d       = 1'b0;
    alu_en_d      = 1'b0;
    cmd_err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_vld) begin
          if (rx_byte == DATA_WIDTH'(OPC_REG_WR)) begin
            state_d = ST_WR_ADDR;
          end else if (rx_byte == DATA_WIDTH'(OPC_REG_RD)) begin
            state_d = ST_RD_ADDR;
          end else if (rx_byte == DATA_WIDTH'(OPC_ALU_OPS)) begin
            state_d = ST_OP_A;
          end else if (rx_byte == DATA_WIDTH'(OPC_ALU_NOP)) begin
            state_d = ST_ALU_FUN;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end

      // Address is only latched here; Address output moves with the strobe
      ST_WR_ADDR: begin
        if (rx_vld) begin
          addr_lat_d = rx_addr;
          state_d    = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        if (rx_vld) begin
          wr_en_d   = 1'b1;
          address_d = addr_lat_q;
          wr_data_d = rx_byte;
          state_d   = ST_IDLE;
        end
      end

      ST_RD_ADDR: begin
        if (rx_vld) begin
          rd_en_d   = 1'b1;
          address_d = rx_addr;
          state_d   = ST_IDLE;
        end
      end

      ST_OP_A: begin
        if (rx_vld) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(OPND_A_ADDR);
          wr_data_d = rx_byte;
          state_d   = ST_OP_B;
        end
      end

      ST_OP_B: begin
        if (rx_vld) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(OPND_B_ADDR);
          wr_data_d = rx_byte;
          state_d   = ST_ALU_FUN;
        end
      end

      // ALU_FUN output stays put until the next ALU command
      ST_ALU_FUN: begin
        if (rx_vld) begin
          alu_en_d      = 1'b1;
          alu_fun_d     = rx_fun;
          clk_gate_en_d = 1'b1;
          state_d       = ST_ALU_WAIT;
        end
      end

      // Bytes arriving while the ALU is busy are dropped and flagged
      ST_ALU_WAIT: begin
        if (rx_vld) begin
          cmd_err_d = 1'b1;
        end
        if (bus.ALU_OUT_valid) begin
          clk_gate_en_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_lat_q    <= '0;
      address_q     <= '0;
      wr_data_q     <= '0;
      alu_fun_q     <= '0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      alu_en_q      <= 1'b0;
      clk_gate_en_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_lat_q    <= addr_lat_d;
      address_q     <= address_d;
      wr_data_q     <= wr_data_d;
      alu_fun_q     <= alu_fun_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      alu_en_q      <= alu_en_d;
      clk_gate_en_q <= clk_gate_en_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign bus.Address     = address_q;
  assign bus.WrEn        = wr_en_q;
  assign bus.RdEn        = rd_en_q;
  assign bus.Wr_data     = wr_data_q;
  assign bus.ALU_FUN     = alu_fun_q;
  assign bus.ALU_EN      = alu_en_q;
  assign bus.CLK_GATE_EN = clk_gate_en_q;
  assign bus.CMD_ERR     = cmd_err_q;

endmodule
